// File: rtl/cs_pkg.sv
// Shared constants for the control sequencer: opcodes, ALU codes, step encodings
// and the bit map of the datapath strobe word.
package cs_pkg;

  localparam int unsigned CTRL_W = 21;

  localparam int unsigned B_PC_OUT    = 0;
  localparam int unsigned B_MAR_IN    = 1;
  localparam int unsigned B_Z_IN      = 2;
  localparam int unsigned B_ZLO_OUT   = 3;
  localparam int unsigned B_PC_IN     = 4;
  localparam int unsigned B_MDR_IN    = 5;
  localparam int unsigned B_MEM_READ  = 6;
  localparam int unsigned B_MDR_OUT   = 7;
  localparam int unsigned B_IR_IN     = 8;
  localparam int unsigned B_GRA       = 9;
  localparam int unsigned B_GRB       = 10;
  localparam int unsigned B_GRC       = 11;
  localparam int unsigned B_R_IN      = 12;
  localparam int unsigned B_R_OUT     = 13;
  localparam int unsigned B_Y_IN      = 14;
  localparam int unsigned B_C_OUT     = 15;
  localparam int unsigned B_BA_OUT    = 16;
  localparam int unsigned B_MEM_WRITE = 17;
  localparam int unsigned B_CON_IN    = 18;
  localparam int unsigned B_IPORT_OUT = 19;
  localparam int unsigned B_OPORT_IN  = 20;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_RLO  = 5'b00011;
  localparam logic [4:0] OPC_RHI  = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_BR   = 5'b10010;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_INC = 5'b11111;

  localparam logic [3:0] TS_IDLE = 4'd0;
  localparam logic [3:0] TS_T0   = 4'd1;
  localparam logic [3:0] TS_T1   = 4'd2;
  localparam logic [3:0] TS_T2   = 4'd3;
  localparam logic [3:0] TS_T3   = 4'd4;
  localparam logic [3:0] TS_T4   = 4'd5;
  localparam logic [3:0] TS_T5   = 4'd6;
  localparam logic [3:0] TS_T6   = 4'd7;
  localparam logic [3:0] TS_T7   = 4'd8;
  localparam logic [3:0] TS_HALT = 4'd15;

  typedef enum logic [3:0] {
    CLS_LD    = 4'd0,
    CLS_ST    = 4'd1,
    CLS_RTYPE = 4'd2,
    CLS_ADDI  = 4'd3,
    CLS_BR    = 4'd4,
    CLS_IN    = 4'd5,
    CLS_OUT   = 4'd6,
    CLS_NOP   = 4'd7,
    CLS_HALT  = 4'd8,
    CLS_ILL   = 4'd9
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(input logic [4:0] op);
    instr_cls_e cls;
    if (op == OPC_LD)                         cls = CLS_LD;
    else if (op == OPC_ST)                    cls = CLS_ST;
    else if ((op >= OPC_RLO) && (op <= OPC_RHI)) cls = CLS_RTYPE;
    else if (op == OPC_ADDI)                  cls = CLS_ADDI;
    else if (op == OPC_BR)                    cls = CLS_BR;
    else if (op == OPC_IN)                    cls = CLS_IN;
    else if (op == OPC_OUT)                   cls = CLS_OUT;
    else if (op == OPC_NOP)                   cls = CLS_NOP;
    else if (op == OPC_HALT)                  cls = CLS_HALT;
    else                                      cls = CLS_ILL;
    return cls;
  endfunction

endpackage

// File: rtl/cs_wait_timer.sv
// Memory-handshake wait timer: loadable down-counter whose expired flag marks
// the last cycle a wait step may spend before the sequencer gives up.
module cs_wait_timer #(
  parameter int unsigned LOAD_VAL = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  logic [7:0] r_count;

  // Load on step entry, count down while the step is held, never wrap below zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= 8'(LOAD_VAL);
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == 8'd1);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps T0..T7 per instruction class, Moore strobe
// decode, memory wait handling with timeout, HALT/fault tracking and retire count.
module control_sequencer
  import cs_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int ALU_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              stall,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              con_ff,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic [ALU_W-1:0]  alu_code,
  output logic [3:0]        t_state,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  logic [3:0]        r_state;
  logic              r_halted;
  logic              r_fault;
  logic [CNT_W-1:0]  r_count;

  logic [4:0]        w_opc;
  instr_cls_e        w_cls;
  logic [3:0]        w_next;
  logic              w_retire;
  logic              w_fault;
  logic              w_expired;
  logic              w_load;
  logic              w_dec;
  logic [CTRL_W-1:0] w_cw;
  logic [4:0]        w_alu_sel;
  logic [CTRL_W-1:0] w_cw_gated;

  // The class is taken at the end of T2, the edge on which IR is loaded.
  assign w_opc = 5'(opcode);
  assign w_cls = decode_cls(w_opc);

  // Next-step selection; a class that changes mid-instruction ends in a fault halt.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_fault  = 1'b0;
    if (stall) begin
      w_next = r_state;
    end else begin
      case (r_state)
        TS_IDLE, TS_HALT: begin
          if (start) w_next = TS_T0;
          else       w_next = r_state;
        end
        TS_T0: w_next = TS_T1;
        TS_T1: begin
          if (mem_ready) begin
            w_next = TS_T2;
          end else if (w_expired) begin
            w_next  = TS_HALT;
            w_fault = 1'b1;
          end else begin
            w_next = r_state;
          end
        end
        TS_T2: begin
          case (w_cls)
            CLS_HALT: begin w_next = TS_HALT; w_retire = 1'b1; end
            CLS_ILL:  begin w_next = TS_HALT; w_fault  = 1'b1; end
            default:  w_next = TS_T3;
          endcase
        end
        TS_T3: begin
          case (w_cls)
            CLS_IN, CLS_OUT, CLS_NOP: begin w_next = TS_T0; w_retire = 1'b1; end
            CLS_RTYPE, CLS_ADDI, CLS_LD, CLS_ST, CLS_BR: w_next = TS_T4;
            default: begin w_next = TS_HALT; w_fault = 1'b1; end
          endcase
        end
        TS_T4: begin
          case (w_cls)
            CLS_RTYPE, CLS_ADDI, CLS_LD, CLS_ST, CLS_BR: w_next = TS_T5;
            default: begin w_next = TS_HALT; w_fault = 1'b1; end
          endcase
        end
        TS_T5: begin
          case (w_cls)
            CLS_RTYPE, CLS_ADDI: begin w_next = TS_T0; w_retire = 1'b1; end
            CLS_LD, CLS_ST, CLS_BR: w_next = TS_T6;
            default: begin w_next = TS_HALT; w_fault = 1'b1; end
          endcase
        end
        TS_T6: begin
          case (w_cls)
            CLS_LD: begin
              if (mem_ready) begin
                w_next = TS_T7;
              end else if (w_expired) begin
                w_next  = TS_HALT;
                w_fault = 1'b1;
              end else begin
                w_next = r_state;
              end
            end
            CLS_ST: w_next = TS_T7;
            CLS_BR: begin w_next = TS_T0; w_retire = 1'b1; end
            default: begin w_next = TS_HALT; w_fault = 1'b1; end
          endcase
        end
        TS_T7: begin
          case (w_cls)
            CLS_LD: begin w_next = TS_T0; w_retire = 1'b1; end
            CLS_ST: begin
              if (mem_ready) begin
                w_next   = TS_T0;
                w_retire = 1'b1;
              end else if (w_expired) begin
                w_next  = TS_HALT;
                w_fault = 1'b1;
              end else begin
                w_next = r_state;
              end
            end
            default: begin w_next = TS_HALT; w_fault = 1'b1; end
          endcase
        end
        default: w_next = TS_IDLE;
      endcase
    end
  end

  // Reloading on every step change covers entry into each wait step.
  assign w_load = !stall && (w_next != r_state);
  assign w_dec  = !stall;

  cs_wait_timer #(
    .LOAD_VAL (MEM_TIMEOUT)
  ) u_wait_timer (
    .clock     (clock),
    .clear     (clear),
    .i_load    (w_load),
    .i_dec     (w_dec),
    .o_expired (w_expired)
  );

  // Step register, retire counter and halt/fault status.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= TS_IDLE;
      r_count  <= {CNT_W{1'b0}};
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
      else          r_count <= r_count;
      if ((w_next == TS_HALT) && (r_state != TS_HALT)) begin
        r_halted <= 1'b1;
        r_fault  <= w_fault;
      end else if ((r_state == TS_HALT) && (w_next == TS_T0)) begin
        r_halted <= 1'b0;
        r_fault  <= 1'b0;
      end else begin
        r_halted <= r_halted;
        r_fault  <= r_fault;
      end
    end
  end

  // Strobe decode from the registered step; PCIn qualifiers follow mem_ready / con_ff.
  always_comb begin
    w_cw      = {CTRL_W{1'b0}};
    w_alu_sel = 5'd0;
    case (r_state)
      TS_T0: begin
        w_cw[B_PC_OUT] = 1'b1; w_cw[B_MAR_IN] = 1'b1; w_cw[B_Z_IN] = 1'b1;
        w_alu_sel = ALU_INC;
      end
      TS_T1: begin
        w_cw[B_ZLO_OUT] = 1'b1; w_cw[B_MDR_IN] = 1'b1; w_cw[B_MEM_READ] = 1'b1;
        w_cw[B_PC_IN]   = mem_ready;
      end
      TS_T2: begin
        w_cw[B_MDR_OUT] = 1'b1; w_cw[B_IR_IN] = 1'b1;
      end
      TS_T3: begin
        case (w_cls)
          CLS_RTYPE, CLS_ADDI: begin w_cw[B_GRB] = 1'b1; w_cw[B_R_OUT] = 1'b1; w_cw[B_Y_IN] = 1'b1; end
          CLS_LD, CLS_ST:      begin w_cw[B_GRB] = 1'b1; w_cw[B_BA_OUT] = 1'b1; w_cw[B_Y_IN] = 1'b1; end
          CLS_BR:  begin w_cw[B_GRA] = 1'b1; w_cw[B_R_OUT] = 1'b1; w_cw[B_CON_IN] = 1'b1; end
          CLS_IN:  begin w_cw[B_IPORT_OUT] = 1'b1; w_cw[B_GRA] = 1'b1; w_cw[B_R_IN] = 1'b1; end
          CLS_OUT: begin w_cw[B_GRA] = 1'b1; w_cw[B_R_OUT] = 1'b1; w_cw[B_OPORT_IN] = 1'b1; end
          default: w_cw = {CTRL_W{1'b0}};
        endcase
      end
      TS_T4: begin
        case (w_cls)
          CLS_RTYPE: begin
            w_cw[B_GRC] = 1'b1; w_cw[B_R_OUT] = 1'b1; w_cw[B_Z_IN] = 1'b1;
            w_alu_sel = w_opc;
          end
          CLS_ADDI, CLS_LD, CLS_ST: begin
            w_cw[B_C_OUT] = 1'b1; w_cw[B_Z_IN] = 1'b1;
            w_alu_sel = ALU_ADD;
          end
          CLS_BR:  begin w_cw[B_PC_OUT] = 1'b1; w_cw[B_Y_IN] = 1'b1; end
          default: w_cw = {CTRL_W{1'b0}};
        endcase
      end
      TS_T5: begin
        case (w_cls)
          CLS_RTYPE, CLS_ADDI: begin w_cw[B_ZLO_OUT] = 1'b1; w_cw[B_GRA] = 1'b1; w_cw[B_R_IN] = 1'b1; end
          CLS_LD, CLS_ST:      begin w_cw[B_ZLO_OUT] = 1'b1; w_cw[B_MAR_IN] = 1'b1; end
          CLS_BR: begin
            w_cw[B_C_OUT] = 1'b1; w_cw[B_Z_IN] = 1'b1;
            w_alu_sel = ALU_ADD;
          end
          default: w_cw = {CTRL_W{1'b0}};
        endcase
      end
      TS_T6: begin
        case (w_cls)
          CLS_LD: begin w_cw[B_MEM_READ] = 1'b1; w_cw[B_MDR_IN] = 1'b1; end
          CLS_ST: begin w_cw[B_GRA] = 1'b1; w_cw[B_R_OUT] = 1'b1; w_cw[B_MDR_IN] = 1'b1; end
          CLS_BR: begin w_cw[B_ZLO_OUT] = 1'b1; w_cw[B_PC_IN] = con_ff; end
          default: w_cw = {CTRL_W{1'b0}};
        endcase
      end
      TS_T7: begin
        case (w_cls)
          CLS_LD:  begin w_cw[B_MDR_OUT] = 1'b1; w_cw[B_GRA] = 1'b1; w_cw[B_R_IN] = 1'b1; end
          CLS_ST:  w_cw[B_MEM_WRITE] = 1'b1;
          default: w_cw = {CTRL_W{1'b0}};
        endcase
      end
      default: w_cw = {CTRL_W{1'b0}};
    endcase
  end

  assign w_cw_gated  = stall ? {CTRL_W{1'b0}} : w_cw;
  assign ctrl_word   = w_cw_gated;
  assign alu_code    = w_cw_gated[B_Z_IN] ? ALU_W'(w_alu_sel) : {ALU_W{1'b0}};
  assign t_state     = r_state;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle bench for control_sequencer with hand-written strobe
// expectations for each step of each instruction class.
module tb_control_sequencer;
  import cs_pkg::*;

  logic              clock = 1'b0;
  logic              clear, start, stall, con_ff, mem_ready;
  logic [4:0]        opcode;
  logic [CTRL_W-1:0] ctrl_word;
  logic [4:0]        alu_code;
  logic [3:0]        t_state;
  logic              halted, fault;
  logic [15:0]       instr_count;

  int n_chk = 0;
  int n_err = 0;

  control_sequencer #(
    .OPC_W(5), .ALU_W(5), .MEM_TIMEOUT(15), .CNT_W(16)
  ) dut (
    .clock(clock), .clear(clear), .start(start), .stall(stall),
    .opcode(opcode), .con_ff(con_ff), .mem_ready(mem_ready),
    .ctrl_word(ctrl_word), .alu_code(alu_code), .t_state(t_state),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  function automatic logic [CTRL_W-1:0] bm(input int unsigned b);
    logic [CTRL_W-1:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Check one step mid-cycle, then advance to just after the next rising edge.
  task automatic step_chk(input string tag, input logic [3:0] ts,
                          input logic [CTRL_W-1:0] cw, input logic [4:0] alu);
    @(negedge clock);
    check_eq({tag, ".ts"}, 32'(t_state), 32'(ts));
    check_eq({tag, ".cw"}, 32'(ctrl_word), 32'(cw));
    check_eq({tag, ".alu"}, 32'(alu_code), 32'(alu));
    @(posedge clock);
    #1;
  endtask

  task automatic wait_step(input string tag, input logic [3:0] ts,
                           input logic [CTRL_W-1:0] cw_wait, input logic [CTRL_W-1:0] cw_done,
                           input int dly);
    for (int i = 0; i < dly; i++) begin
      mem_ready = 1'b0;
      step_chk(tag, ts, cw_wait, 5'd0);
    end
    mem_ready = 1'b1;
    step_chk(tag, ts, cw_done, 5'd0);
    mem_ready = 1'b0;
  endtask

  task automatic fetch(input int dly);
    step_chk("T0", TS_T0, bm(B_PC_OUT) | bm(B_MAR_IN) | bm(B_Z_IN), ALU_INC);
    wait_step("T1", TS_T1, bm(B_ZLO_OUT) | bm(B_MDR_IN) | bm(B_MEM_READ),
              bm(B_ZLO_OUT) | bm(B_MDR_IN) | bm(B_MEM_READ) | bm(B_PC_IN), dly);
    step_chk("T2", TS_T2, bm(B_MDR_OUT) | bm(B_IR_IN), 5'd0);
  endtask

  task automatic chk_status(input string tag, input logic h, input logic f, input int cnt);
    check_eq({tag, ".halted"}, 32'(halted), 32'(h));
    check_eq({tag, ".fault"}, 32'(fault), 32'(f));
    check_eq({tag, ".count"}, 32'(instr_count), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; start = 1'b0; stall = 1'b0; con_ff = 1'b0; mem_ready = 1'b0;
    opcode = 5'b00101;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    check_eq("rst.ts", 32'(t_state), 32'(TS_IDLE));
    check_eq("rst.cw", 32'(ctrl_word), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 0);

    // R-type 00101, memory ready immediately
    start = 1'b1;
    step_chk("idle", TS_IDLE, '0, 5'd0);
    start = 1'b0;
    fetch(0);
    step_chk("R.T3", TS_T3, bm(B_GRB) | bm(B_R_OUT) | bm(B_Y_IN), 5'd0);
    step_chk("R.T4", TS_T4, bm(B_GRC) | bm(B_R_OUT) | bm(B_Z_IN), 5'b00101);
    step_chk("R.T5", TS_T5, bm(B_ZLO_OUT) | bm(B_GRA) | bm(B_R_IN), 5'd0);
    check_eq("R.ts", 32'(t_state), 32'(TS_T0));
    chk_status("R", 1'b0, 1'b0, 1);

    // LD with three-cycle memory latency in T1 and T6
    opcode = OPC_LD;
    fetch(3);
    step_chk("LD.T3", TS_T3, bm(B_GRB) | bm(B_BA_OUT) | bm(B_Y_IN), 5'd0);
    step_chk("LD.T4", TS_T4, bm(B_C_OUT) | bm(B_Z_IN), ALU_ADD);
    step_chk("LD.T5", TS_T5, bm(B_ZLO_OUT) | bm(B_MAR_IN), 5'd0);
    wait_step("LD.T6", TS_T6, bm(B_MEM_READ) | bm(B_MDR_IN), bm(B_MEM_READ) | bm(B_MDR_IN), 3);
    step_chk("LD.T7", TS_T7, bm(B_MDR_OUT) | bm(B_GRA) | bm(B_R_IN), 5'd0);
    chk_status("LD", 1'b0, 1'b0, 2);

    // BR not taken, then taken
    opcode = OPC_BR;
    for (int k = 0; k < 2; k++) begin
      con_ff = (k == 1);
      fetch(0);
      step_chk("BR.T3", TS_T3, bm(B_GRA) | bm(B_R_OUT) | bm(B_CON_IN), 5'd0);
      step_chk("BR.T4", TS_T4, bm(B_PC_OUT) | bm(B_Y_IN), 5'd0);
      step_chk("BR.T5", TS_T5, bm(B_C_OUT) | bm(B_Z_IN), ALU_ADD);
      step_chk("BR.T6", TS_T6, (k == 1) ? (bm(B_ZLO_OUT) | bm(B_PC_IN)) : bm(B_ZLO_OUT), 5'd0);
      chk_status("BR", 1'b0, 1'b0, 3 + k);
    end
    con_ff = 1'b0;

    // ADDI with a two-cycle stall in T4
    opcode = OPC_ADDI;
    fetch(0);
    step_chk("AD.T3", TS_T3, bm(B_GRB) | bm(B_R_OUT) | bm(B_Y_IN), 5'd0);
    stall = 1'b1;
    step_chk("AD.stall", TS_T4, '0, 5'd0);
    step_chk("AD.stall", TS_T4, '0, 5'd0);
    stall = 1'b0;
    step_chk("AD.T4", TS_T4, bm(B_C_OUT) | bm(B_Z_IN), ALU_ADD);
    step_chk("AD.T5", TS_T5, bm(B_ZLO_OUT) | bm(B_GRA) | bm(B_R_IN), 5'd0);
    chk_status("AD", 1'b0, 1'b0, 5);

    // IN, with stall overriding mem_ready in T1
    opcode = OPC_IN;
    step_chk("IN.T0", TS_T0, bm(B_PC_OUT) | bm(B_MAR_IN) | bm(B_Z_IN), ALU_INC);
    stall = 1'b1; mem_ready = 1'b1;
    step_chk("IN.stall", TS_T1, '0, 5'd0);
    stall = 1'b0;
    wait_step("IN.T1", TS_T1, '0, bm(B_ZLO_OUT) | bm(B_MDR_IN) | bm(B_MEM_READ) | bm(B_PC_IN), 0);
    step_chk("IN.T2", TS_T2, bm(B_MDR_OUT) | bm(B_IR_IN), 5'd0);
    step_chk("IN.T3", TS_T3, bm(B_IPORT_OUT) | bm(B_GRA) | bm(B_R_IN), 5'd0);
    chk_status("IN", 1'b0, 1'b0, 6);

    opcode = OPC_NOP;
    fetch(0);
    step_chk("NOP.T3", TS_T3, '0, 5'd0);
    chk_status("NOP", 1'b0, 1'b0, 7);

    // Illegal opcode halts with fault and is not counted
    opcode = 5'b11111;
    fetch(0);
    check_eq("ILL.ts", 32'(t_state), 32'(TS_HALT));
    chk_status("ILL", 1'b1, 1'b1, 7);
    start = 1'b1;
    step_chk("ILL.halt", TS_HALT, '0, 5'd0);
    start = 1'b0;
    check_eq("ILL.restart", 32'(t_state), 32'(TS_T0));
    chk_status("ILL.clr", 1'b0, 1'b0, 7);

    opcode = OPC_HALT;
    fetch(0);
    check_eq("HLT.ts", 32'(t_state), 32'(TS_HALT));
    chk_status("HLT", 1'b1, 1'b0, 8);
    start = 1'b1;
    step_chk("HLT.halt", TS_HALT, '0, 5'd0);
    start = 1'b0;

    // Timeout: 15 T1 cycles without mem_ready
    opcode = 5'b00101;
    step_chk("TO.T0", TS_T0, bm(B_PC_OUT) | bm(B_MAR_IN) | bm(B_Z_IN), ALU_INC);
    for (int i = 0; i < 15; i++)
      step_chk("TO.T1", TS_T1, bm(B_ZLO_OUT) | bm(B_MDR_IN) | bm(B_MEM_READ), 5'd0);
    check_eq("TO.ts", 32'(t_state), 32'(TS_HALT));
    chk_status("TO", 1'b1, 1'b1, 8);
    start = 1'b1;
    step_chk("TO.halt", TS_HALT, '0, 5'd0);
    start = 1'b0;
    chk_status("TO.clr", 1'b0, 1'b0, 8);

    // mem_ready on the final permitted cycle still completes
    opcode = OPC_NOP;
    fetch(14);
    step_chk("EDGE.T3", TS_T3, '0, 5'd0);
    chk_status("EDGE", 1'b0, 1'b0, 9);

    // ST completing after one wait cycle in T7
    opcode = OPC_ST;
    fetch(0);
    step_chk("ST.T3", TS_T3, bm(B_GRB) | bm(B_BA_OUT) | bm(B_Y_IN), 5'd0);
    step_chk("ST.T4", TS_T4, bm(B_C_OUT) | bm(B_Z_IN), ALU_ADD);
    step_chk("ST.T5", TS_T5, bm(B_ZLO_OUT) | bm(B_MAR_IN), 5'd0);
    step_chk("ST.T6", TS_T6, bm(B_GRA) | bm(B_R_OUT) | bm(B_MDR_IN), 5'd0);
    wait_step("ST.T7", TS_T7, bm(B_MEM_WRITE), bm(B_MEM_WRITE), 1);
    chk_status("ST", 1'b0, 1'b0, 10);

    // clear during the T7 store wait beats start and mem_ready
    fetch(0);
    step_chk("ST2.T3", TS_T3, bm(B_GRB) | bm(B_BA_OUT) | bm(B_Y_IN), 5'd0);
    step_chk("ST2.T4", TS_T4, bm(B_C_OUT) | bm(B_Z_IN), ALU_ADD);
    step_chk("ST2.T5", TS_T5, bm(B_ZLO_OUT) | bm(B_MAR_IN), 5'd0);
    step_chk("ST2.T6", TS_T6, bm(B_GRA) | bm(B_R_OUT) | bm(B_MDR_IN), 5'd0);
    step_chk("ST2.T7", TS_T7, bm(B_MEM_WRITE), 5'd0);
    clear = 1'b1; start = 1'b1; mem_ready = 1'b1;
    step_chk("ST2.clr", TS_T7, bm(B_MEM_WRITE), 5'd0);
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0;
    check_eq("CLR.ts", 32'(t_state), 32'(TS_IDLE));
    check_eq("CLR.cw", 32'(ctrl_word), 32'd0);
    check_eq("CLR.alu", 32'(alu_code), 32'd0);
    chk_status("CLR", 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
